// File: rtl/softex_tcdm_responder_pkg.sv
// Shared types and constants for the SoftEx TCDM memory-side responder.
package softex_tcdm_responder_pkg;

  localparam int unsigned TCDM_RESP_DW = 32;
  localparam int unsigned TCDM_RESP_UW = 1;

  localparam int unsigned TCDM_RESP_DEFAULT_LATENCY = 1;
  localparam int unsigned TCDM_RESP_DEFAULT_DEPTH   = 4;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] tcdm_resp_lfsr_taps = 16'hB400;

  // One buffered read response: data word plus the user bits of the request
  typedef struct packed {
    logic [TCDM_RESP_UW-1:0] user;
    logic [TCDM_RESP_DW-1:0] data;
  } tcdm_resp_entry_t;

  function automatic logic [15:0] tcdm_resp_lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & tcdm_resp_lfsr_taps)};
  endfunction

endpackage

// File: rtl/softex_tcdm_responder_if.sv
// HCI-core style request/response bundle between the streamer and the responder.
interface softex_tcdm_responder_if
  import softex_tcdm_responder_pkg::*;
#(
  parameter int unsigned AW = 32
);
  logic                        req;
  logic                        gnt;
  logic [AW-1:0]               add;
  logic                        wen;
  logic [TCDM_RESP_DW/8-1:0]   be;
  logic [TCDM_RESP_DW-1:0]     data;
  logic [TCDM_RESP_UW-1:0]     user;
  logic [TCDM_RESP_DW-1:0]     r_data;
  logic [TCDM_RESP_UW-1:0]     r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport master (
    output req, add, wen, be, data, user, r_ready,
    input  gnt, r_data, r_user, r_valid
  );

  modport slave (
    input  req, add, wen, be, data, user, r_ready,
    output gnt, r_data, r_user, r_valid
  );
endinterface

// File: rtl/softex_tcdm_resp_fifo.sv
// Fall-through response FIFO: the head entry is visible as soon as it is stored.
module softex_tcdm_resp_fifo
  import softex_tcdm_responder_pkg::*;
#(
  parameter int unsigned DEPTH = TCDM_RESP_DEFAULT_DEPTH,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  tcdm_resp_entry_t entry_i,
  input  logic             pop_i,
  output logic             valid_o,
  output tcdm_resp_entry_t entry_o,
  output logic [CW-1:0]    count_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  tcdm_resp_entry_t store_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;

  // Storage, pointers and occupancy; clear drops every entry but keeps storage contents
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) store_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        store_q[wptr_q] <= entry_i;
        wptr_q <= (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
      end
      if (pop_i) rptr_q <= (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign valid_o = (count_q != '0);
  assign entry_o = store_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/softex_tcdm_responder.sv
// Word-addressed flop memory answering TCDM requests with fixed read latency,
// credit-based response buffering and, with SOFTEX_TCDM_RESP_STALL_EN defined,
// pseudo-random grant stalls driven by a 16-bit LFSR.
module softex_tcdm_responder
  import softex_tcdm_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 256,
  parameter int unsigned LATENCY    = TCDM_RESP_DEFAULT_LATENCY,
  parameter int unsigned RESP_DEPTH = TCDM_RESP_DEFAULT_DEPTH,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  softex_tcdm_responder_if.slave        tcdm,
  output logic                          busy_o,
  output logic [31:0]                   n_reads_o,
  output logic [31:0]                   n_writes_o
);
  localparam int unsigned BW  = TCDM_RESP_DW / 8;
  localparam int unsigned OFS = $clog2(BW);
  localparam int unsigned IW  = $clog2(MEM_WORDS);
  localparam int unsigned CW  = $clog2(RESP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);

  logic [TCDM_RESP_DW-1:0] mem_q [MEM_WORDS];
  logic [IW-1:0]           word_idx;
  logic [CW-1:0]           outstanding_q, outstanding_d, fifo_count;
  logic                    busy_q;
  logic [31:0]             n_reads_q, n_writes_q;
  logic                    stall, credit_ok, rd_acc, wr_acc, pop;
  logic                    push_valid, fifo_valid;
  tcdm_resp_entry_t        rd_entry, push_entry, head_entry;

  assign word_idx  = tcdm.add[OFS +: IW];
  assign credit_ok = (outstanding_q < DEPTH_C);
  assign rd_acc    = tcdm.gnt &  tcdm.wen;
  assign wr_acc    = tcdm.gnt & ~tcdm.wen;
  assign pop       = fifo_valid & tcdm.r_ready;

`ifdef SOFTEX_TCDM_RESP_STALL_EN
  logic [15:0] lfsr_q;

  // Stall LFSR advances every cycle and restarts from the seed on clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      lfsr_q <= STALL_SEED;
    else if (clear_i) lfsr_q <= STALL_SEED;
    else              lfsr_q <= tcdm_resp_lfsr_next(lfsr_q);
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Grant: reads need a free credit, clear and stalls block everything
  always_comb begin
    tcdm.gnt = tcdm.req & ~clear_i & ~stall & (~tcdm.wen | credit_ok);
  end

  // Memory sample for a read accepted this cycle
  always_comb begin
    rd_entry      = '0;
    rd_entry.data = mem_q[word_idx];
    rd_entry.user = tcdm.user;
  end

  // Byte-masked write into the array on an accepted write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem_q[i] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < int'(BW); b++)
        if (tcdm.be[b]) mem_q[word_idx][8*b +: 8] <= tcdm.data[8*b +: 8];
    end
  end

  generate
    if (LATENCY == 1) begin : g_no_delay
      assign push_valid = rd_acc;
      assign push_entry = rd_entry;
    end else begin : g_delay
      logic             dl_valid_q [LATENCY-1];
      tcdm_resp_entry_t dl_entry_q [LATENCY-1];

      // Delay line carrying sampled reads towards the response FIFO
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < int'(LATENCY) - 1; i++) begin
            dl_valid_q[i] <= 1'b0;
            dl_entry_q[i] <= '0;
          end
        end else if (clear_i) begin
          for (int i = 0; i < int'(LATENCY) - 1; i++) dl_valid_q[i] <= 1'b0;
        end else begin
          dl_valid_q[0] <= rd_acc;
          dl_entry_q[0] <= rd_entry;
          for (int i = 1; i < int'(LATENCY) - 1; i++) begin
            dl_valid_q[i] <= dl_valid_q[i-1];
            dl_entry_q[i] <= dl_entry_q[i-1];
          end
        end
      end

      assign push_valid = dl_valid_q[LATENCY-2];
      assign push_entry = dl_entry_q[LATENCY-2];
    end
  endgenerate

  softex_tcdm_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push_valid & (fifo_count != DEPTH_C)),
    .entry_i (push_entry),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .entry_o (head_entry),
    .count_o (fifo_count)
  );

  assign tcdm.r_valid = fifo_valid;
  assign tcdm.r_data  = head_entry.data;
  assign tcdm.r_user  = head_entry.user;

  // Next credit count: a pop only frees its credit once registered
  always_comb begin
    outstanding_d = outstanding_q;
    if (rd_acc)  outstanding_d = outstanding_d + CW'(1);
    if (pop)     outstanding_d = outstanding_d - CW'(1);
    if (clear_i) outstanding_d = '0;
  end

  // Credit, busy flag and request counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      busy_q        <= 1'b0;
      n_reads_q     <= '0;
      n_writes_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      busy_q        <= (outstanding_d != '0);
      n_reads_q     <= n_reads_q + 32'(rd_acc);
      n_writes_q    <= n_writes_q + 32'(wr_acc);
    end
  end

  assign busy_o     = busy_q;
  assign n_reads_o  = n_reads_q;
  assign n_writes_o = n_writes_q;

endmodule

// File: tb/tb_softex_tcdm_responder.sv
// Directed bench for softex_tcdm_responder (MEM_WORDS=256, LATENCY=3, RESP_DEPTH=4).
// Also exercises grant stalls when built with SOFTEX_TCDM_RESP_STALL_EN.
module tb_softex_tcdm_responder;
  import softex_tcdm_responder_pkg::*;

  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WORDS = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        busy;
  logic [31:0] n_reads, n_writes;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;

  logic [31:0] model_mem [WORDS];
  logic [32:0] exp_q [$];
  logic [32:0] sb_entry;
  logic [7:0]  sb_idx;

  softex_tcdm_responder_if tcdm ();

  softex_tcdm_responder #(
    .MEM_WORDS  (WORDS),
    .LATENCY    (LAT),
    .RESP_DEPTH (DEPTH),
    .STALL_SEED (16'hACE1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .tcdm       (tcdm),
    .busy_o     (busy),
    .n_reads_o  (n_reads),
    .n_writes_o (n_writes)
  );

  always #5 clk = ~clk;

  // Free-running cycle index used for latency measurements
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard: reference memory plus in-order queue of expected responses
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < int'(WORDS); i++) model_mem[i] = '0;
    end else if (clear) begin
      exp_q.delete();
    end else begin
      if (tcdm.r_valid && tcdm.r_ready) begin
        if (exp_q.size() == 0) checkOutput("resp_unexpected", 1, 0);
        else begin
          sb_entry = exp_q.pop_front();
          checkOutput("resp_order", {tcdm.r_user, tcdm.r_data}, sb_entry);
        end
      end
      if (tcdm.req && tcdm.gnt) begin
        sb_idx = tcdm.add[9:2];
        if (tcdm.wen) exp_q.push_back({tcdm.user, model_mem[sb_idx]});
        else
          for (int b = 0; b < 4; b++)
            if (tcdm.be[b]) model_mem[sb_idx][8*b +: 8] = tcdm.data[8*b +: 8];
      end
    end
  end

  // Hold one request until granted; returns the cycle index of the grant
  task automatic applyStimulus(input logic wen, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be, output int grant_cycle);
    logic granted;
    granted     = 1'b0;
    grant_cycle = -1;
    tcdm.req  = 1'b1;
    tcdm.wen  = wen;
    tcdm.add  = addr;
    tcdm.data = data;
    tcdm.be   = be;
    tcdm.user = addr[2];
    for (int i = 0; i < 40 && !granted; i++) begin
      #2;
      if (tcdm.gnt) begin
        granted     = 1'b1;
        grant_cycle = cycle_cnt;
      end
      @(posedge clk); #1;
    end
    tcdm.req = 1'b0;
    if (!granted) checkOutput("gnt_timeout", 0, 1);
  endtask

  task automatic readLatency(input logic [31:0] addr, input logic [31:0] exp_data, input string tag);
    int g;
    int seen;
    seen = -1;
    applyStimulus(1'b1, addr, 32'h0, 4'h0, g);
    for (int i = 0; i < 20 && seen < 0; i++) begin
      if (tcdm.r_valid) begin
        seen = cycle_cnt;
        checkOutput(tag, tcdm.r_data, exp_data);
      end
      @(posedge clk); #1;
    end
    checkOutput({tag, "_latency"}, 64'(seen - g), 64'(LAT));
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int g, c0, grants, nxt, first_v, last_v, nr, nw, low;
    logic [31:0] d0;
    logic [63:0] pat_a, pat_b;

    tcdm.req = 1'b0; tcdm.wen = 1'b0; tcdm.add = '0; tcdm.data = '0;
    tcdm.be = '0; tcdm.user = '0; tcdm.r_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_gnt", tcdm.gnt, 0);
    checkOutput("rst_rvalid", tcdm.r_valid, 0);
    checkOutput("rst_rdata", tcdm.r_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_nreads", n_reads, 0);
    checkOutput("rst_nwrites", n_writes, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] write/read word 5 with latency");
    applyStimulus(1'b0, 32'h14, 32'hDEADBEEF, 4'hF, g);
    readLatency(32'h14, 32'hDEADBEEF, "raw_word5");
    checkOutput("cnt_writes_1", n_writes, 1);
    checkOutput("cnt_reads_1", n_reads, 1);

    $display("[TB] byte enables");
    applyStimulus(1'b0, 32'h1C, 32'h11223344, 4'hF, g);
    applyStimulus(1'b0, 32'h1C, 32'hAABBCCDD, 4'b1010, g);
    readLatency(32'h1C, 32'hAA22CC44, "be_1010");
    applyStimulus(1'b0, 32'h20, 32'h11223344, 4'hF, g);
    applyStimulus(1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, g);
    readLatency(32'h20, 32'h11BB33DD, "be_0101");

    $display("[TB] address wrap");
    readLatency(32'h0, 32'h0, "word0_init");
    applyStimulus(1'b0, 32'h400, 32'hCAFEF00D, 4'hF, g);
    readLatency(32'h0, 32'hCAFEF00D, "wrap_0x400");
    readLatency(32'h414, 32'hDEADBEEF, "wrap_0x414");

    $display("[TB] backpressure and credits");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, (16 + i) * 4, 32'h5A000000 | i, 4'hF, g);
    nr = n_reads;
    tcdm.r_ready = 1'b0;
    grants = 0;
    nxt = 0;
    for (int c = 0; c < 20; c++) begin
      tcdm.req = 1'b1; tcdm.wen = 1'b1; tcdm.add = (16 + nxt) * 4; tcdm.user = tcdm.add[2];
      #2;
      if (tcdm.gnt) begin
        grants++;
        nxt++;
      end
      @(posedge clk); #1;
    end
    tcdm.req = 1'b0;
    checkOutput("bp_grants", grants, 4);
    checkOutput("bp_busy", busy, 1);
    checkOutput("bp_rvalid", tcdm.r_valid, 1);
    d0 = tcdm.r_data;
    @(posedge clk); #1;
    checkOutput("bp_stable", tcdm.r_data, d0);
    checkOutput("bp_head", tcdm.r_data, 32'h5A000000);
    tcdm.r_ready = 1'b1;
    tcdm.req = 1'b1; tcdm.wen = 1'b1; tcdm.add = 20 * 4; tcdm.user = 1'b0;
    #2;
    c0 = cycle_cnt;
    checkOutput("full_pop_gnt", tcdm.gnt, 0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 20 * 4, 32'h0, 4'h0, g);
`ifndef SOFTEX_TCDM_RESP_STALL_EN
    checkOutput("full_pop_regrant", g, c0 + 1);
`endif
    for (int i = 21; i < 24; i++) applyStimulus(1'b1, i * 4, 32'h0, 4'h0, g);
    for (int i = 0; i < 40 && (exp_q.size() != 0 || tcdm.r_valid); i++) begin
      @(posedge clk); #1;
    end
    checkOutput("bp_drain", exp_q.size(), 0);
    checkOutput("bp_nreads", n_reads, nr + 8);
    @(posedge clk); #1;
    checkOutput("bp_idle_busy", busy, 0);

`ifndef SOFTEX_TCDM_RESP_STALL_EN
    $display("[TB] back-to-back responses");
    first_v = -1; last_v = -1; nxt = 0;
    for (int c = 0; c < 14; c++) begin
      tcdm.req = (nxt < 4); tcdm.wen = 1'b1; tcdm.add = (16 + nxt) * 4; tcdm.user = tcdm.add[2];
      #2;
      if (tcdm.gnt) nxt++;
      if (tcdm.r_valid) begin
        if (first_v < 0) first_v = cycle_cnt;
        last_v = cycle_cnt;
      end
      @(posedge clk); #1;
    end
    tcdm.req = 1'b0;
    checkOutput("b2b_span", last_v - first_v, 3);
`endif

    $display("[TB] clear");
    tcdm.r_ready = 1'b0;
    applyStimulus(1'b1, 32'h14, 32'h0, 4'h0, g);
    applyStimulus(1'b1, 32'h40, 32'h0, 4'h0, g);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("clr_pre_rvalid", tcdm.r_valid, 1);
    nr = n_reads;
    nw = n_writes;
    clear = 1'b1;
    tcdm.req = 1'b1; tcdm.wen = 1'b1; tcdm.add = 32'h14;
    #2;
    checkOutput("clr_gnt", tcdm.gnt, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    tcdm.req = 1'b0;
    checkOutput("clr_rvalid", tcdm.r_valid, 0);
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_nreads", n_reads, nr);
    checkOutput("clr_nwrites", n_writes, nw);
    tcdm.r_ready = 1'b1;
    readLatency(32'h14, 32'hDEADBEEF, "clr_mem_kept");

`ifdef SOFTEX_TCDM_RESP_STALL_EN
    $display("[TB] stall rate and repeatability");
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    low = 0; pat_a = '0;
    tcdm.req = 1'b1; tcdm.wen = 1'b0; tcdm.add = 32'h3FC; tcdm.be = 4'h0;
    for (int c = 0; c < 1000; c++) begin
      #2;
      if (!tcdm.gnt) low++;
      if (c < 64) pat_a[c] = tcdm.gnt;
      @(posedge clk); #1;
    end
    checkOutput("stall_rate", (low >= 200 && low <= 300), 1);
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    pat_b = '0;
    for (int c = 0; c < 64; c++) begin
      #2;
      pat_b[c] = tcdm.gnt;
      @(posedge clk); #1;
    end
    tcdm.req = 1'b0;
    checkOutput("stall_repeat", pat_b, pat_a);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
